// File: rtl/tel_pkg.sv
// Shared types, default widths and the round-robin helper for the tick event logger.
package tel_pkg;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_CNT_W  = 32;
  localparam int unsigned DEF_TS_W   = 16;

  localparam int unsigned CH_W  = $clog2(DEF_NUM_CH);
  localparam int unsigned TAP_W = $clog2(DEF_CNT_W);

  // Event record in the default configuration.
  typedef struct packed {
    logic [CH_W-1:0]      ch;
    logic [DEF_TS_W-1:0]  ts;
    logic [DEF_CNT_W-1:0] cnt;
  } evt_t;

  // Grant pointer after a push: the channel following the winner, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned winner, input int unsigned n);
    return (winner + 1 >= n) ? 0 : winner + 1;
  endfunction

endpackage

// File: rtl/tel_sync_fifo.sv
// Registered show-ahead FIFO: the head entry is presented while not empty.
module tel_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;

  // Accept a push when there is room or the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop_i && !empty_q;
    do_push  = push_i && (!full_q || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
    full_d  = (count_d == (PtrW + 1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Head is forced to zero when empty so stale entries never leak out.
  always_comb begin
    rdata_o = empty_q ? '0 : mem_q[rd_ptr_q];
    full_o  = full_q;
    empty_o = empty_q;
  end

endmodule

// File: rtl/tick_event_logger.sv
// Counter bank with tap-bit rise detection, per-channel pending records,
// round-robin arbitration into an event FIFO and saturating drop accounting.
module tick_event_logger
  import tel_pkg::*;
#(
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned TS_W       = DEF_TS_W,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DROP_W     = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CH-1:0]                 en,
  input  logic [NUM_CH-1:0]                 clr,
  input  logic [NUM_CH*$clog2(CNT_W)-1:0]   tap_sel,
  output logic [NUM_CH*CNT_W-1:0]           cnt,
  output logic                              evt_valid,
  input  logic                              evt_ready,
  output logic [$clog2(NUM_CH)-1:0]         evt_ch,
  output logic [TS_W-1:0]                   evt_ts,
  output logic [CNT_W-1:0]                  evt_cnt,
  output logic                              fifo_full,
  output logic [DROP_W-1:0]                 drop_cnt
);

  localparam int unsigned ChW  = $clog2(NUM_CH);
  localparam int unsigned TapW = $clog2(CNT_W);

  typedef struct packed {
    logic [ChW-1:0]   ch;
    logic [TS_W-1:0]  ts;
    logic [CNT_W-1:0] cnt;
  } rec_t;

  localparam int unsigned RecW = $bits(rec_t);

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] pend_q, pend_d;
  rec_t              rec_q [NUM_CH];
  rec_t              rec_d [NUM_CH];
  logic [ChW-1:0]    ptr_q, ptr_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [DROP_W:0]   drop_sum;
  int unsigned       n_drop;

  logic              grant_vld;
  logic [ChW-1:0]    grant_ch;
  logic [ChW-1:0]    idx_c;
  int unsigned       idx;
  logic              push, pop;
  logic              fifo_empty, fifo_full_w;
  logic [RecW-1:0]   fifo_rdata;
  rec_t              head_rec;

  // Counter next values (clear beats enable) and tap-bit rise detection.
  always_comb begin
    rise = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (clr[i]) begin
        cnt_d[i] = '0;
      end else if (en[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      rise[i] = !cnt_q[i][tap_sel[i*TapW +: TapW]] && cnt_d[i][tap_sel[i*TapW +: TapW]];
    end
    ts_d = ts_q + 1'b1;
  end

  // Round-robin search over pending channels starting at the grant pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = 0;
    idx_c     = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end
      idx_c = ChW'(idx);
      if (!grant_vld && pend_q[idx_c]) begin
        grant_vld = 1'b1;
        grant_ch  = idx_c;
      end
    end
    pop   = !fifo_empty && evt_ready;
    push  = grant_vld && (!fifo_full_w || pop);
    ptr_d = push ? ChW'(rr_next(32'(grant_ch), NUM_CH)) : ptr_q;
  end

  // Pending-record update; a rise on a granted channel re-latches without a drop.
  always_comb begin
    pend_d = pend_q;
    rec_d  = rec_q;
    n_drop = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rise[i]) begin
        pend_d[i]     = 1'b1;
        rec_d[i].ch   = ChW'(i);
        rec_d[i].ts   = ts_q;
        rec_d[i].cnt  = cnt_d[i];
        if (pend_q[i] && !(push && grant_ch == ChW'(i))) begin
          n_drop++;
        end
      end else if (push && grant_ch == ChW'(i)) begin
        pend_d[i] = 1'b0;
      end
    end
    drop_sum = {1'b0, drop_q} + (DROP_W + 1)'(n_drop);
    drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  // State registers for counters, timestamp, pending records, pointer and drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q   <= '0;
      pend_q <= '0;
      ptr_q  <= '0;
      drop_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        rec_q[i] <= '0;
      end
    end else begin
      ts_q   <= ts_d;
      pend_q <= pend_d;
      ptr_q  <= ptr_d;
      drop_q <= drop_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        rec_q[i] <= rec_d[i];
      end
    end
  end

  tel_sync_fifo #(
    .WIDTH (RecW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i (rec_q[grant_ch]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full_w),
    .empty_o (fifo_empty)
  );

  // Output mapping.
  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
    head_rec  = rec_t'(fifo_rdata);
    evt_valid = !fifo_empty;
    evt_ch    = head_rec.ch;
    evt_ts    = head_rec.ts;
    evt_cnt   = head_rec.cnt;
    fifo_full = fifo_full_w;
    drop_cnt  = drop_q;
  end

endmodule

// File: tb/tb_tick_event_logger.sv
// Bench for tick_event_logger: directed scenarios plus random traffic against a queue model.
module tb_tick_event_logger;

  localparam int NCH   = 4;
  localparam int CW    = 8;
  localparam int TW    = 16;
  localparam int DEPTH = 8;
  localparam int DW    = 4;
  localparam int CHW   = 2;
  localparam int TAPW  = 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NCH-1:0]       en = '0;
  logic [NCH-1:0]       clr = '0;
  logic [NCH*TAPW-1:0]  tap_sel = '0;
  logic [NCH*CW-1:0]    cnt;
  logic                 evt_valid;
  logic                 evt_ready = 1'b0;
  logic [CHW-1:0]       evt_ch;
  logic [TW-1:0]        evt_ts;
  logic [CW-1:0]        evt_cnt;
  logic                 fifo_full;
  logic [DW-1:0]        drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tick_event_logger #(
    .NUM_CH     (NCH),
    .CNT_W      (CW),
    .TS_W       (TW),
    .FIFO_DEPTH (DEPTH),
    .DROP_W     (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .tap_sel   (tap_sel),
    .cnt       (cnt),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_ts    (evt_ts),
    .evt_cnt   (evt_cnt),
    .fifo_full (fifo_full),
    .drop_cnt  (drop_cnt)
  );

  // Reference model: integer counters, pending slots and a record queue.
  typedef struct {
    int ch;
    int ts;
    int cnt;
  } mrec_t;

  int    m_cnt [NCH];
  bit    m_pend [NCH];
  mrec_t m_rec [NCH];
  mrec_t m_q [$];
  int    m_ptr;
  int    m_drop;
  int    m_ts;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c]  = 0;
      m_pend[c] = 1'b0;
      m_rec[c]  = '{0, 0, 0};
    end
    m_q.delete();
    m_ptr  = 0;
    m_drop = 0;
    m_ts   = 0;
  endtask

  task automatic model_step();
    bit    pop;
    int    win;
    mrec_t pushed;
    int    newc;
    int    tap;
    bit    rise;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pop = (m_q.size() > 0) && evt_ready;
    win = -1;
    pushed = '{0, 0, 0};
    if (m_q.size() < DEPTH || pop) begin
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (m_ptr + k) % NCH;
        if (win < 0 && m_pend[c]) win = c;
      end
    end
    if (win >= 0) pushed = m_rec[win];
    for (int c = 0; c < NCH; c++) begin
      newc = clr[c] ? 0 : (en[c] ? (m_cnt[c] + 1) % (1 << CW) : m_cnt[c]);
      tap  = int'(tap_sel[c*TAPW +: TAPW]);
      rise = (((m_cnt[c] >> tap) & 1) == 0) && (((newc >> tap) & 1) == 1);
      if (rise) begin
        if (m_pend[c] && c != win) m_drop = (m_drop < (1 << DW) - 1) ? m_drop + 1 : m_drop;
        m_pend[c] = 1'b1;
        m_rec[c]  = '{c, m_ts, newc};
      end else if (c == win) begin
        m_pend[c] = 1'b0;
      end
      m_cnt[c] = newc;
    end
    if (pop) void'(m_q.pop_front());
    if (win >= 0) begin
      m_q.push_back(pushed);
      m_ptr = (win + 1) % NCH;
    end
    m_ts = (m_ts + 1) % (1 << TW);
  endtask

  // One clock edge; outputs are sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = '1;
    clr = '0;
    tap_sel = '0;
    evt_ready = 1'b0;
    repeat (3) begin
      cycle();
      vectors++;
      if (cnt !== '0 || evt_valid !== 1'b0 || drop_cnt !== '0 || fifo_full !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold: cnt=%h valid=%b drop=%0d full=%b, want all zero",
                 cnt, evt_valid, drop_cnt, fifo_full);
      end
    end
  endtask

  // Continues straight out of test_reset, so the first record carries ts 0.
  task automatic test_single();
    int  n_rec;
    bit  exp_valid;
    en = 4'b0001;
    tap_sel = '0;
    evt_ready = 1'b1;
    rst_n = 1'b1;
    n_rec = 0;
    for (int n = 1; n <= 20; n++) begin
      cycle();
      exp_valid = (n % 2 == 0);
      vectors++;
      if (cnt[CW-1:0] !== CW'(n)) begin
        miscompares++;
        $display("FAIL single_cnt: edge %0d got %0d want %0d", n, cnt[CW-1:0], n);
      end
      vectors++;
      if (evt_valid !== exp_valid) begin
        miscompares++;
        $display("FAIL single_valid: edge %0d got %b want %b", n, evt_valid, exp_valid);
      end
      if (evt_valid) begin
        vectors++;
        if (evt_cnt !== CW'(2 * n_rec + 1) || evt_ts !== TW'(2 * n_rec) || evt_ch !== 2'd0) begin
          miscompares++;
          $display("FAIL single_rec: rec %0d got ch%0d cnt %0d ts %0d want ch0 cnt %0d ts %0d",
                   n_rec, evt_ch, evt_cnt, evt_ts, 2 * n_rec + 1, 2 * n_rec);
        end
        n_rec++;
      end
    end
  endtask

  task automatic test_simultaneous();
    bit exp_valid;
    int exp_ch;
    int base;
    do_reset();
    en = '1;
    clr = '0;
    tap_sel = {3'd2, 3'd2, 3'd2, 3'd2};
    evt_ready = 1'b1;
    rst_n = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      cycle();
      exp_valid = 1'b0;
      exp_ch = 0;
      base = 0;
      for (int b = 0; b < 2; b++) begin
        if (n >= 4 + 8 * b + 1 && n <= 4 + 8 * b + 4) begin
          exp_valid = 1'b1;
          base = 4 + 8 * b;
          exp_ch = n - base - 1;
        end
      end
      vectors++;
      if (evt_valid !== exp_valid) begin
        miscompares++;
        $display("FAIL simul_valid: edge %0d got %b want %b", n, evt_valid, exp_valid);
      end
      if (exp_valid) begin
        vectors++;
        if (evt_ch !== CHW'(exp_ch) || evt_cnt !== CW'(base) || evt_ts !== TW'(base - 1)) begin
          miscompares++;
          $display("FAIL simul_rec: edge %0d got ch%0d cnt %0d ts %0d want ch%0d cnt %0d ts %0d",
                   n, evt_ch, evt_cnt, evt_ts, exp_ch, base, base - 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_drop;
    int k;
    int exp_c;
    do_reset();
    en = 4'b0001;
    clr = '0;
    tap_sel = '0;
    evt_ready = 1'b0;
    rst_n = 1'b1;
    for (int n = 1; n <= 23; n++) begin
      cycle();
      exp_drop = (n >= 19) ? (n - 17) / 2 : 0;
      vectors++;
      if (fifo_full !== (n >= 16) || drop_cnt !== DW'(exp_drop)) begin
        miscompares++;
        $display("FAIL bp_fill: edge %0d got full=%b drop=%0d want full=%b drop=%0d",
                 n, fifo_full, drop_cnt, (n >= 16), exp_drop);
      end
      if (n >= 2) begin
        vectors++;
        if (evt_valid !== 1'b1 || evt_cnt !== 8'd1 || evt_ts !== 16'd0) begin
          miscompares++;
          $display("FAIL bp_stable: edge %0d got valid=%b cnt %0d ts %0d want 1/1/0",
                   n, evt_valid, evt_cnt, evt_ts);
        end
      end
    end
    en = '0;
    evt_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 11; i++) begin
      if (evt_valid) begin
        exp_c = (k < 8) ? 2 * k + 1 : 23;
        vectors++;
        if (evt_cnt !== CW'(exp_c) || evt_ts !== TW'(exp_c - 1) || evt_ch !== 2'd0) begin
          miscompares++;
          $display("FAIL bp_drain: rec %0d got ch%0d cnt %0d ts %0d want ch0 cnt %0d ts %0d",
                   k, evt_ch, evt_cnt, evt_ts, exp_c, exp_c - 1);
        end
        k++;
      end
      cycle();
    end
    vectors++;
    if (k !== 9 || drop_cnt !== 4'd3 || evt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_total: got %0d recs drop=%0d valid=%b want 9 recs drop=3 valid=0",
               k, drop_cnt, evt_valid);
    end
  endtask

  task automatic test_boundary();
    bit exp_valid;
    do_reset();
    en = 4'b0001;
    clr = '0;
    tap_sel = {3'd0, 3'd0, 3'd0, 3'd7};
    evt_ready = 1'b1;
    rst_n = 1'b1;
    for (int n = 1; n <= 448; n++) begin
      cycle();
      exp_valid = (n == 129) || (n == 385);
      vectors++;
      if (evt_valid !== exp_valid || cnt[CW-1:0] !== CW'(n % 256)) begin
        miscompares++;
        $display("FAIL bound_run: edge %0d got valid=%b cnt %0d want valid=%b cnt %0d",
                 n, evt_valid, cnt[CW-1:0], exp_valid, n % 256);
      end
      if (exp_valid) begin
        vectors++;
        if (evt_cnt !== 8'h80 || evt_ts !== TW'(n - 2)) begin
          miscompares++;
          $display("FAIL bound_rec: edge %0d got cnt %h ts %0d want cnt 80 ts %0d",
                   n, evt_cnt, evt_ts, n - 2);
        end
      end
    end
    // Counter sits at 0xC0 here; clear together with enable.
    clr = 4'b0001;
    cycle();
    vectors++;
    if (cnt[CW-1:0] !== 8'h00) begin
      miscompares++;
      $display("FAIL bound_clr: got cnt %h want 00", cnt[CW-1:0]);
    end
    clr = '0;
    en = '0;
    repeat (2) begin
      cycle();
      vectors++;
      if (evt_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL bound_clr_evt: got valid=%b want 0", evt_valid);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    en = '1;
    clr = '0;
    tap_sel = '0;
    evt_ready = 1'b0;
    rst_n = 1'b1;
    repeat (6) cycle();
    vectors++;
    if (evt_valid !== 1'b1 || drop_cnt !== DW'(m_drop) || m_q.size() != 5) begin
      miscompares++;
      $display("FAIL mid_pre: got valid=%b drop=%0d want valid=1 drop=%0d (5 queued)",
               evt_valid, drop_cnt, m_drop);
    end
    rst_n = 1'b0;
    cycle();
    vectors++;
    if (evt_valid !== 1'b0 || fifo_full !== 1'b0 || drop_cnt !== '0 || cnt !== '0 ||
        evt_ch !== '0 || evt_ts !== '0 || evt_cnt !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got valid=%b full=%b drop=%0d cnt=%h rec=%0d/%0d/%0d want 0",
               evt_valid, fifo_full, drop_cnt, cnt, evt_ch, evt_ts, evt_cnt);
    end
    rst_n = 1'b1;
    en = '0;
    repeat (3) begin
      cycle();
      vectors++;
      if (evt_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_after: got valid=%b want 0", evt_valid);
      end
    end
  endtask

  task automatic test_random();
    mrec_t head;
    do_reset();
    rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        en[c]  = ($urandom_range(0, 3) != 0);
        clr[c] = ($urandom_range(0, 19) == 0);
        tap_sel[c*TAPW +: TAPW] = ($urandom_range(0, 7) == 0) ?
                                  TAPW'($urandom_range(0, 7)) : TAPW'($urandom_range(0, 3));
      end
      evt_ready = ($urandom_range(0, 1) != 0);
      rst_n = ($urandom_range(0, 399) != 0);
      cycle();
      for (int c = 0; c < NCH; c++) begin
        vectors++;
        if (cnt[c*CW +: CW] !== CW'(m_cnt[c])) begin
          miscompares++;
          $display("FAIL rand_cnt: cycle %0d ch%0d got %0d want %0d",
                   n, c, cnt[c*CW +: CW], m_cnt[c]);
        end
      end
      head = (m_q.size() > 0) ? m_q[0] : '{0, 0, 0};
      vectors++;
      if (evt_valid !== (m_q.size() > 0) || fifo_full !== (m_q.size() == DEPTH) ||
          drop_cnt !== DW'(m_drop)) begin
        miscompares++;
        $display("FAIL rand_flags: cycle %0d got valid=%b full=%b drop=%0d want %b/%b/%0d",
                 n, evt_valid, fifo_full, drop_cnt, (m_q.size() > 0),
                 (m_q.size() == DEPTH), m_drop);
      end
      vectors++;
      if (evt_ch !== CHW'(head.ch) || evt_ts !== TW'(head.ts) || evt_cnt !== CW'(head.cnt)) begin
        miscompares++;
        $display("FAIL rand_head: cycle %0d got ch%0d ts %0d cnt %0d want ch%0d ts %0d cnt %0d",
                 n, evt_ch, evt_ts, evt_cnt, head.ch, head.ts, head.cnt);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_boundary();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
